inst_fetch_ctrl: RTL and testbench

INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

---
 rtl/inst_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_inst_fetch_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding read, fixed-latency capture,
// ready/valid hand-off to the core and PC/retirement update on completion.
//
// state | meaning
// IDLE  | no fetch in progress, waiting for fetch_en
// FETCH | instrmem_rd strobe cycle, PC held
// WAIT  | latency down-counter running, capture at terminal count
// HOLD  | instr_out offered with instr_valid until instr_ready
// EXEC  | instruction accepted, waiting for complete_instr
module inst_fetch_ctrl #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [15:0] RESET_PC    = 16'h3000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [15:0] PC,
    output logic        instrmem_rd,
    input  logic [15:0] instr_dout,
    output logic        instr_valid,
    output logic [15:0] instr_out,
    input  logic        instr_ready,
    input  logic        complete_instr,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] retired_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        EXEC  = 3'd4
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] out_q, out_d;
    logic [15:0] ret_q, ret_d;
    logic        rd_q;
    logic        valid_q;
    logic [1:0]  warm_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        out_d   = out_q;
        ret_d   = ret_q;
        case (state_q)
            IDLE: begin
                // warm_q[1] keeps the first read two cycles clear of reset release
                if (fetch_en && warm_q[1]) state_d = FETCH;
            end
            FETCH: begin
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    out_d   = instr_dout;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HOLD: begin
                if (instr_ready) state_d = EXEC;
            end
            EXEC: begin
                if (complete_instr) begin
                    pc_d    = br_taken ? br_target : pc_q + 16'd1;
                    ret_d   = (ret_q == 16'hFFFF) ? ret_q : ret_q + 16'd1;
                    state_d = fetch_en ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            pc_q    <= RESET_PC;
            out_q   <= 16'h0000;
            ret_q   <= 16'h0000;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            warm_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            ret_q   <= ret_d;
            rd_q    <= (state_d == FETCH);
            valid_q <= (state_d == HOLD);
            warm_q  <= {warm_q[0], 1'b1};
        end
    end

    assign PC          = pc_q;
    assign instrmem_rd = rd_q;
    assign instr_valid = valid_q;
    assign instr_out   = out_q;
    assign retired_cnt = ret_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed vector table, latency/reset sequences on a
// MEM_LATENCY=3 copy, and randomized traffic against a transaction-level model.
module tb_inst_fetch_ctrl;

    localparam int LAT1 = 1;

    logic        clk;
    logic        rst, fe, rdy, cpl, bt;
    logic [15:0] tgt, dout;
    logic [15:0] pc, out, ret;
    logic        rd, valid;

    logic        rst3, fe3, rdy3, cpl3, bt3;
    logic [15:0] tgt3, dout3;
    logic [15:0] pc3, out3, ret3;
    logic        rd3, valid3;

    int n_chk  = 0;
    int n_pass = 0;

    // model: phase 0 idle, 1 read outstanding, 2 offered, 3 accepted
    int          m_phase = 0, m_age = 0, m_warm = 0;
    logic [15:0] m_pc = 16'h3000, m_ret = 16'h0, m_out = 16'h0;
    logic        m_rd = 1'b0;

    inst_fetch_ctrl #(.MEM_LATENCY(LAT1), .RESET_PC(16'h3000)) u_dut1 (
        .clock(clk), .reset(rst), .fetch_en(fe), .PC(pc), .instrmem_rd(rd),
        .instr_dout(dout), .instr_valid(valid), .instr_out(out), .instr_ready(rdy),
        .complete_instr(cpl), .br_taken(bt), .br_target(tgt), .retired_cnt(ret)
    );

    inst_fetch_ctrl #(.MEM_LATENCY(3), .RESET_PC(16'h3000)) u_dut3 (
        .clock(clk), .reset(rst3), .fetch_en(fe3), .PC(pc3), .instrmem_rd(rd3),
        .instr_dout(dout3), .instr_valid(valid3), .instr_out(out3), .instr_ready(rdy3),
        .complete_instr(cpl3), .br_taken(bt3), .br_target(tgt3), .retired_cnt(ret3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hBEEF);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic model_step();
        if (!rst) begin
            m_phase = 0; m_age = 0; m_warm = 0; m_rd = 1'b0;
            m_pc = 16'h3000; m_ret = 16'h0; m_out = 16'h0;
        end else begin
            m_rd = 1'b0;
            case (m_phase)
                0: if (fe && m_warm >= 2) begin m_phase = 1; m_age = 0; m_rd = 1'b1; end
                1: begin
                    m_age++;
                    if (m_age == LAT1 + 1) begin m_out = dout; m_phase = 2; end
                end
                2: if (rdy) m_phase = 3;
                default: if (cpl) begin
                    m_pc = bt ? tgt : m_pc + 16'd1;
                    if (m_ret != 16'hFFFF) m_ret++;
                    if (fe) begin m_phase = 1; m_age = 0; m_rd = 1'b1; end
                    else m_phase = 0;
                end
            endcase
            if (m_warm < 2) m_warm++;
        end
    endtask

    // memory returns real data only in the cycle MEM_LATENCY after the strobe
    task automatic tick();
        dout = (m_phase == 1 && m_age == LAT1) ? mem(m_pc) : 16'($urandom);
        @(posedge clk);
        #1;
        model_step();
        chk("m_rd", {15'd0, rd}, {15'd0, m_rd});
        chk("m_valid", {15'd0, valid}, (m_phase == 2) ? 16'd1 : 16'd0);
        chk("m_pc", pc, m_pc);
        chk("m_out", out, m_out);
        chk("m_ret", ret, m_ret);
    endtask

    typedef struct {
        logic        rst, fe, rdy, cpl, bt;
        logic [15:0] tgt;
        logic        rd, v;
        logic [15:0] pc, out, ret;
    } vec_t;

    function automatic vec_t mk(input logic r, f, y, c, b, input logic [15:0] t,
                                input logic erd, ev, input logic [15:0] epc, eout, eret);
        vec_t x;
        x.rst = r; x.fe = f; x.rdy = y; x.cpl = c; x.bt = b; x.tgt = t;
        x.rd = erd; x.v = ev; x.pc = epc; x.out = eout; x.ret = eret;
        return x;
    endfunction

    task automatic do_instr(input logic b, input logic [15:0] t, input int hold);
        int n;
        fe = 1'b1; rdy = 1'b0; cpl = 1'b0; bt = 1'b0;
        n = 0;
        while (!valid && n < 20) begin tick(); n++; end
        chk("instr_valid_timeout", {15'd0, valid}, 16'd1);
        for (int i = 0; i < hold; i++) tick();
        rdy = 1'b1; tick();
        rdy = 1'b0; cpl = 1'b1; bt = b; tgt = t; tick();
        cpl = 1'b0; bt = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        logic seen;
        logic [15:0] ret_before;

        rst = 1'b0; fe = 1'b0; rdy = 1'b0; cpl = 1'b0; bt = 1'b0; tgt = 16'h0; dout = 16'h0;
        rst3 = 1'b0; fe3 = 1'b0; rdy3 = 1'b0; cpl3 = 1'b0; bt3 = 1'b0; tgt3 = 16'h0; dout3 = 16'h0;

        // MEM_LATENCY=3 copy: capture timing, then reset while in WAIT
        tick(); tick();
        rst3 = 1'b1; fe3 = 1'b1;
        n = 0;
        while (!rd3 && n < 10) begin tick(); n++; end
        chk("l3_first_rd", {15'd0, rd3}, 16'd1);
        chk("l3_rd_pc", pc3, 16'h3000);
        for (int i = 0; i < 4; i++) begin
            dout3 = (i == 3) ? 16'hABCD : 16'h0BAD;
            tick();
            if (i < 3) chk("l3_no_early_valid", {15'd0, valid3}, 16'd0);
        end
        chk("l3_valid", {15'd0, valid3}, 16'd1);
        chk("l3_out", out3, 16'hABCD);
        rdy3 = 1'b1; tick();
        rdy3 = 1'b0; cpl3 = 1'b1; tick();
        cpl3 = 1'b0;
        chk("l3_ret", ret3, 16'd1);
        chk("l3_pc_inc", pc3, 16'h3001);
        chk("l3_refetch", {15'd0, rd3}, 16'd1);
        tick(); tick();
        rst3 = 1'b0; tick();
        chk("l3_rst_pc", pc3, 16'h3000);
        chk("l3_rst_ret", ret3, 16'd0);
        chk("l3_rst_valid", {15'd0, valid3}, 16'd0);
        chk("l3_rst_rd", {15'd0, rd3}, 16'd0);
        rst3 = 1'b1; fe3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); seen = seen | valid3 | rd3; end
        chk("l3_no_pulse_after_rst", {15'd0, seen}, 16'd0);

        //            rst   fe    rdy   cpl   bt    tgt       rd    v     pc        out       ret
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 16'h3000, 16'h0000, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h3000, 16'h0000, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3000, 16'h1234, 16'd0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b1, 16'h3000, 16'h1234, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h3000, 16'h1234, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 16'h3000, 16'h1234, 16'd0));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b1, 1'b0, 16'h4000, 16'h1234, 16'd1));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 16'h1234, 16'd1));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4000, 16'hFEEF, 16'd1));
        tbl.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4000, 16'hFEEF, 16'd1));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4001, 16'hFEEF, 16'd2));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4001, 16'hFEEF, 16'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4001, 16'hFEEF, 16'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h4001, 16'hFEEE, 16'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4001, 16'hFEEE, 16'd2));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4002, 16'hFEEE, 16'd3));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h4002, 16'hFEEE, 16'd3));

        foreach (tbl[i]) begin
            rst = tbl[i].rst; fe = tbl[i].fe; rdy = tbl[i].rdy;
            cpl = tbl[i].cpl; bt = tbl[i].bt; tgt = tbl[i].tgt;
            tick();
            chk($sformatf("tbl_rd[%0d]", i), {15'd0, rd}, {15'd0, tbl[i].rd});
            chk($sformatf("tbl_valid[%0d]", i), {15'd0, valid}, {15'd0, tbl[i].v});
            chk($sformatf("tbl_pc[%0d]", i), pc, tbl[i].pc);
            chk($sformatf("tbl_out[%0d]", i), out, tbl[i].out);
            chk($sformatf("tbl_ret[%0d]", i), ret, tbl[i].ret);
        end
        cpl = 1'b0; bt = 1'b0; rdy = 1'b0;

        // PC wrap from FFFF
        do_instr(1'b1, 16'hFFFF, 0);
        chk("pc_at_ffff", pc, 16'hFFFF);
        do_instr(1'b0, 16'h1111, 2);
        chk("pc_wrap", pc, 16'h0000);
        chk("ret_after_wrap", ret, 16'd5);

        // fetch_en dropped while waiting on memory
        fe = 1'b1;
        n = 0;
        while (!rd && n < 20) begin tick(); n++; end
        chk("drop_rd_seen", {15'd0, rd}, 16'd1);
        tick();
        fe = 1'b0;
        ret_before = ret;
        n = 0;
        while (!valid && n < 20) begin tick(); n++; end
        chk("drop_delivered", {15'd0, valid}, 16'd1);
        rdy = 1'b1; tick();
        rdy = 1'b0; cpl = 1'b1; tick();
        cpl = 1'b0;
        chk("drop_retired", ret, ret_before + 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(); seen = seen | rd | valid; end
        chk("drop_idle_no_rd", {15'd0, seen}, 16'd0);

        // randomized traffic, model checks every cycle
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            fe  = ($urandom_range(0, 7) != 0);
            rdy = 1'($urandom);
            cpl = 1'($urandom);
            bt  = ($urandom_range(0, 3) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
